// File: rtl/alu_div.sv
// alu_div: sequential radix-2 restoring divider for the cpu2 execute stage.
// One quotient bit per cycle in CALC; FIX applies signs and special cases
// and writes the registered results and ALU-layout flags.
module alu_div #(
  parameter int WIDTH = 32,
  // Flag bit positions, matching the ALU flag byte layout
  parameter int CIDX  = 0,
  parameter int VIDX  = 1,
  parameter int ZIDX  = 2,
  parameter int SIDX  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] di,
  input  logic [WIDTH-1:0] bi,
  input  logic [7:0]       fi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic [7:0]       fo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Operand context captured at launch; untouched until the next accepted start
  typedef struct packed {
    logic [WIDTH-1:0] bmag;   // divisor magnitude
    logic [WIDTH-1:0] draw;   // dividend as given (divide-by-zero remainder)
    logic             qneg;   // negate quotient in FIX
    logic             rneg;   // negate remainder in FIX
    logic             ovf;    // signed MIN / -1
    logic             dz;     // divisor was zero
    logic [7:0]       f;      // incoming flags
  } op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pr;       // partial remainder
  logic [WIDTH-1:0] dq;       // dividend bits shifting out, quotient bits shifting in

  logic             accept;
  logic [WIDTH-1:0] di_mag, bi_mag;
  logic [WIDTH:0]   pr_sh, diff;
  logic             borrow;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [7:0]       fo_fix;

  assign accept = start && (state == IDLE || state == DONE);

  // Launch-time operand magnitudes
  always_comb begin
    di_mag = (sgn && di[WIDTH-1]) ? -di : di;
    bi_mag = (sgn && bi[WIDTH-1]) ? -bi : bi;
  end

  // One restoring step: shift, trial-subtract, borrow decides the quotient bit.
  // pr < bmag always holds, so bit WIDTH of the difference is exactly the borrow.
  always_comb begin
    pr_sh  = {pr, dq[WIDTH-1]};
    diff   = pr_sh - {1'b0, op.bmag};
    borrow = diff[WIDTH];
  end

  // Final results and flags as written in FIX
  always_comb begin
    q_fix = op.dz ? '1     : (op.qneg ? -dq : dq);
    r_fix = op.dz ? op.draw : (op.rneg ? -pr : pr);
    fo_fix       = op.f;
    fo_fix[CIDX] = op.dz;
    fo_fix[VIDX] = op.ovf;
    fo_fix[ZIDX] = (q_fix == '0);
    fo_fix[SIDX] = q_fix[WIDTH-1];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (bi == '0) ? FIX : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? ((bi == '0) ? FIX : CALC) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, publish in FIX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op   <= '0;
      cnt  <= '0;
      pr   <= '0;
      dq   <= '0;
      quo  <= '0;
      rem  <= '0;
      fo   <= '0;
      div0 <= 1'b0;
    end else begin
      if (accept) begin
        op.bmag <= bi_mag;
        op.draw <= di;
        op.qneg <= sgn & (di[WIDTH-1] ^ bi[WIDTH-1]);
        op.rneg <= sgn & di[WIDTH-1];
        op.ovf  <= sgn && (di == {1'b1, {(WIDTH-1){1'b0}}}) && (bi == '1);
        op.dz   <= (bi == '0);
        op.f    <= fi;
        cnt     <= CW'(WIDTH);
        pr      <= '0;
        dq      <= di_mag;
      end else if (state == CALC) begin
        pr  <= borrow ? pr_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        dq  <= {dq[WIDTH-2:0], ~borrow};
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        quo  <= q_fix;
        rem  <= r_fix;
        fo   <= fo_fix;
        div0 <= op.dz;
      end
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: directed vectors for alu_div with a scoreboard queue; a monitor
// pops and checks on every done pulse, including start-to-done latency.
module tb_alu_div;

  logic        clk = 1'b0;
  logic        reset, start, sgn;
  logic [31:0] di, bi;
  logic [7:0]  fi;
  logic        busy, done, div0;
  logic [31:0] quo, rem;
  logic [7:0]  fo;

  alu_div #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sgn(sgn),
    .di(di), .bi(bi), .fi(fi),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .fo(fo), .div0(div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] q, r;
    logic [7:0]  f;
    logic        dz;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) begin
      checks++; errs++;
      $display("FAIL busy_done_overlap at cycle %0d", cyc);
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, ".quo"},  quo,  mon_e.q);
        chk({mon_e.name, ".rem"},  rem,  mon_e.r);
        chk({mon_e.name, ".fo"},   {24'd0, fo},   {24'd0, mon_e.f});
        chk({mon_e.name, ".div0"}, {31'd0, div0}, {31'd0, mon_e.dz});
        chk({mon_e.name, ".busy"}, {31'd0, busy}, 32'd0);
        chk({mon_e.name, ".latency"}, cyc - mon_e.t0, mon_e.lat);
      end
    end
  end

  // Drive one start pulse from a negedge and record the expected response
  task automatic issue(input string nm, input bit s, input logic [31:0] d, input logic [31:0] b,
                       input logic [7:0] f, input logic [31:0] eq, input logic [31:0] er,
                       input logic [7:0] ef, input bit edz, input int lat);
    exp_t e;
    sgn = s; di = d; bi = b; fi = f; start = 1'b1;
    e.name = nm; e.q = eq; e.r = er; e.f = ef; e.dz = edz; e.t0 = cyc; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; sgn = ~s; di = 32'hDEAD_BEEF; bi = 32'h0BAD_F00D; fi = 8'h5A;
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errs++;
      $display("FAIL %s.timeout: %0d results outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".busy"}, {31'd0, busy}, 32'd0);
    chk({nm, ".done"}, {31'd0, done}, 32'd0);
    chk({nm, ".quo"},  quo, 32'd0);
    chk({nm, ".rem"},  rem, 32'd0);
    chk({nm, ".fo"},   {24'd0, fo}, 32'd0);
    chk({nm, ".div0"}, {31'd0, div0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; sgn = 1'b0; di = '0; bi = '0; fi = '0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    issue("u100_7", 0, 32'd100, 32'd7, 8'hA5, 32'd14, 32'd2, 8'hA0, 0, 34);                       wait_empty("u100_7");
    issue("s-7_2",  1, 32'hFFFF_FFF9, 32'd2, 8'h00, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 8'h08, 0, 34);   wait_empty("s-7_2");
    issue("s7_-2",  1, 32'd7, 32'hFFFF_FFFE, 8'h50, 32'hFFFF_FFFD, 32'd1, 8'h58, 0, 34);          wait_empty("s7_-2");
    issue("s-8_-3", 1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 8'h00, 32'd2, 32'hFFFF_FFFE, 8'h00, 0, 34);  wait_empty("s-8_-3");
    issue("dz",     0, 32'h1234, 32'd0, 8'h30, 32'hFFFF_FFFF, 32'h1234, 8'h39, 1, 2);             wait_empty("dz");
    issue("sdz",    1, 32'hFFFF_FFFB, 32'd0, 8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 8'h09, 1, 2);   wait_empty("sdz");
    issue("u0_5",   0, 32'd0, 32'd5, 8'h0F, 32'd0, 32'd0, 8'h04, 0, 34);                          wait_empty("u0_5");
    issue("ovf",    1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h00, 32'h8000_0000, 32'd0, 8'h0A, 0, 34);  wait_empty("ovf");

    // Start re-pulsed mid-operation must be ignored
    issue("uffff_1", 0, 32'hFFFF_FFFF, 32'd1, 8'hC0, 32'hFFFF_FFFF, 32'd0, 8'hC8, 0, 34);
    repeat (8) @(negedge clk);
    sgn = 1'b1; di = 32'd9; bi = 32'd3; fi = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Relaunch in the DONE cycle itself
    for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
    if (done !== 1'b1) begin
      checks++; errs++;
      $display("FAIL uffff_1.done_wait: done=%b, expected 1", done);
    end
    issue("b2b", 0, 32'd1000, 32'd10, 8'h60, 32'd100, 32'd0, 8'h60, 0, 34);
    wait_empty("b2b");

    // Reset in the middle of a division aborts it
    issue("aborted", 0, 32'd5000, 32'd7, 8'hFF, 32'd714, 32'd2, 8'hF0, 0, 34);
    repeat (14) @(negedge clk);
    chk("abort.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    chk_reset_vals("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort.idle", {31'd0, busy}, 32'd0);

    issue("post_rst", 0, 32'd12345, 32'd100, 8'h90, 32'd123, 32'd45, 8'h90, 0, 34);
    wait_empty("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
